// File: rtl/add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : add_arbiter (with carry_sel_adder, csa_rca)
// Brief    : Round-robin front end sharing one 16-bit carry-select adder
//            between two valid/ready requesters, tagged response channel.
// Revision : 1.0  initial release
// ============================================================================

module csa_rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] w_c;

    assign w_c[0] = cin_i;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_fa
            assign sum_o[g]  = a_i[g] ^ b_i[g] ^ w_c[g];
            assign w_c[g+1]  = (a_i[g] & b_i[g]) | (w_c[g] & (a_i[g] ^ b_i[g]));
        end
    endgenerate

    assign cout_o = w_c[WIDTH];
endmodule

module carry_sel_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int C_NBLK = WIDTH / BLOCK;

    logic [C_NBLK:0] w_carry;

    assign w_carry[0] = cin_i;

    generate
        for (genvar g = 0; g < C_NBLK; g++) begin : g_blk
            if (g == 0) begin : g_first
                csa_rca #(.WIDTH(BLOCK)) u_rca (
                    .a_i    (a_i[g*BLOCK +: BLOCK]),
                    .b_i    (b_i[g*BLOCK +: BLOCK]),
                    .cin_i  (w_carry[g]),
                    .sum_o  (sum_o[g*BLOCK +: BLOCK]),
                    .cout_o (w_carry[g+1])
                );
            end else begin : g_sel
                logic [BLOCK-1:0] w_s0;
                logic [BLOCK-1:0] w_s1;
                logic             w_c0;
                logic             w_c1;

                // Both carry-in hypotheses are computed up front; the real
                // carry from the lower block only drives the select.
                csa_rca #(.WIDTH(BLOCK)) u_rca0 (
                    .a_i    (a_i[g*BLOCK +: BLOCK]),
                    .b_i    (b_i[g*BLOCK +: BLOCK]),
                    .cin_i  (1'b0),
                    .sum_o  (w_s0),
                    .cout_o (w_c0)
                );
                csa_rca #(.WIDTH(BLOCK)) u_rca1 (
                    .a_i    (a_i[g*BLOCK +: BLOCK]),
                    .b_i    (b_i[g*BLOCK +: BLOCK]),
                    .cin_i  (1'b1),
                    .sum_o  (w_s1),
                    .cout_o (w_c1)
                );

                assign sum_o[g*BLOCK +: BLOCK] = w_carry[g] ? w_s1 : w_s0;
                assign w_carry[g+1]            = w_carry[g] ? w_c1 : w_c0;
            end
        end
    endgenerate

    assign cout_o = w_carry[C_NBLK];
endmodule

module add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             last_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic             rsp_valid_q;
    logic             rsp_id_q;
    logic [WIDTH-1:0] rsp_sum_q;
    logic             rsp_cout_q;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_acc0;
    logic             w_acc1;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // On a tie the requester that was not served last wins.
    assign w_grant0 = req0_valid && (!req1_valid || last_q);
    assign w_grant1 = req1_valid && (!req0_valid || !last_q);
    assign w_acc0   = (state_q == ST_IDLE) && w_grant0;
    assign w_acc1   = (state_q == ST_IDLE) && w_grant1;

    carry_sel_adder #(.WIDTH(WIDTH), .BLOCK(4)) u_adder (
        .a_i    (a_q),
        .b_i    (b_q),
        .cin_i  (1'b0),
        .sum_o  (w_sum),
        .cout_o (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (w_acc0 || w_acc1) state_d = ST_CALC;
            ST_CALC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = w_acc0;
        req1_ready = w_acc1;
        busy       = (state_q != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q      <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_sum_q   <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            if (w_acc0) begin
                a_q    <= req0_a;
                b_q    <= req0_b;
                id_q   <= 1'b0;
                last_q <= 1'b0;
            end else if (w_acc1) begin
                a_q    <= req1_a;
                b_q    <= req1_b;
                id_q   <= 1'b1;
                last_q <= 1'b1;
            end
            if (state_q == ST_CALC) begin
                rsp_sum_q   <= w_sum;
                rsp_cout_q  <= w_cout;
                rsp_id_q    <= id_q;
                rsp_valid_q <= 1'b1;
            end else if ((state_q == ST_RESP) && rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
endmodule

`default_nettype wire

// File: tb/tb_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_add_arbiter
// Brief    : Directed self-checking bench for add_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_add_arbiter;
    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic        req0_ready;
    logic [15:0] req0_a;
    logic [15:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [15:0] req1_a;
    logic [15:0] req1_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    add_arbiter #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic id, input logic [15:0] sum, input logic cout);
        chk({tag, " valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, " id"},    {31'd0, rsp_id},    {31'd0, id});
        chk({tag, " sum"},   {16'd0, rsp_sum},   {16'd0, sum});
        chk({tag, " cout"},  {31'd0, rsp_cout},  {31'd0, cout});
    endtask

    task automatic chk_rdy(input string tag, input logic r0, input logic r1);
        chk({tag, " req0_ready"}, {31'd0, req0_ready}, {31'd0, r0});
        chk({tag, " req1_ready"}, {31'd0, req1_ready}, {31'd0, r1});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;

        // Reset and a single operation from requester 0
        do_reset();
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_id",    {31'd0, rsp_id},    32'd0);
        chk("rst rsp_sum",   {16'd0, rsp_sum},   32'd0);
        chk("rst rsp_cout",  {31'd0, rsp_cout},  32'd0);
        chk("rst busy",      {31'd0, busy},      32'd0);
        chk_rdy("rst", 1'b0, 1'b0);
        req0_valid = 1'b1; req0_a = 16'h00F2; req0_b = 16'h000A;
        #1;
        chk_rdy("single idle", 1'b1, 1'b0);
        step();
        req0_valid = 1'b0;
        chk("single calc busy", {31'd0, busy}, 32'd1);
        chk("single calc rsp_valid", {31'd0, rsp_valid}, 32'd0);
        step();
        chk_rsp("single", 1'b0, 16'h00FC, 1'b0);
        rsp_ready = 1'b1;
        step();
        chk("single done rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("single done busy", {31'd0, busy}, 32'd0);

        // Tie arbitration from reset: 0, then 1, then 0 again
        do_reset();
        req0_valid = 1'b1; req0_a = 16'h12FF; req0_b = 16'h3401;
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'h0001;
        #1;
        chk_rdy("tie1", 1'b1, 1'b0);
        step();
        chk_rdy("tie1 calc", 1'b0, 1'b0);
        step();
        chk_rsp("tie1", 1'b0, 16'h4700, 1'b0);
        chk_rdy("tie1 resp", 1'b0, 1'b0);
        step();
        chk_rdy("tie2", 1'b0, 1'b1);
        step();
        step();
        chk_rsp("tie2", 1'b1, 16'h0000, 1'b1);
        step();
        chk_rdy("tie3", 1'b1, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk_rdy("tie idle", 1'b0, 1'b0);
        step();

        // Backpressure, with both requesters pushing while busy
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 16'hFFFF; req1_b = 16'hFFFF;
        #1;
        chk_rdy("bp idle", 1'b0, 1'b1);
        step();
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111;
        req1_a = 16'h5555; req1_b = 16'h0101;
        #1;
        chk_rdy("bp calc", 1'b0, 1'b0);
        chk("bp calc busy", {31'd0, busy}, 32'd1);
        step();
        for (int i = 0; i < 5; i++) begin
            chk_rsp("bp hold", 1'b1, 16'hFFFE, 1'b1);
            chk_rdy("bp hold", 1'b0, 1'b0);
            chk("bp hold busy", {31'd0, busy}, 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp done rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("bp done busy", {31'd0, busy}, 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        chk_rdy("bp idle after", 1'b0, 1'b0);

        // Single-requester streaming: accepts exactly 3 cycles apart
        req1_valid = 1'b1; req1_a = 16'hF201; req1_b = 16'h0A01;
        #1;
        chk_rdy("stream0", 1'b0, 1'b1);
        step();
        req1_a = 16'h0000; req1_b = 16'h0000;
        #1;
        chk_rdy("stream0 calc", 1'b0, 1'b0);
        step();
        chk_rsp("stream0", 1'b1, 16'hFC02, 1'b0);
        chk_rdy("stream0 resp", 1'b0, 1'b0);
        step();
        chk_rdy("stream1", 1'b0, 1'b1);
        step();
        req1_a = 16'hFFFF; req1_b = 16'h0001;
        step();
        chk_rsp("stream1", 1'b1, 16'h0000, 1'b0);
        step();
        chk_rdy("stream2", 1'b0, 1'b1);
        step();
        req1_valid = 1'b0;
        step();
        chk_rsp("stream2", 1'b1, 16'h0000, 1'b1);
        step();
        chk("stream done busy", {31'd0, busy}, 32'd0);

        // Reset during CALC discards the operation
        req1_valid = 1'b1; req1_a = 16'h0001; req1_b = 16'h0001;
        step();
        req1_valid = 1'b0;
        chk("midrst calc busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        step();
        chk("midrst after rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("midrst after rsp_sum", {16'd0, rsp_sum}, 32'd0);
        req0_valid = 1'b1; req0_a = 16'h8000; req0_b = 16'h8000;
        req1_valid = 1'b1; req1_a = 16'h0002; req1_b = 16'h0003;
        #1;
        chk_rdy("midrst tie", 1'b1, 1'b0);
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
        chk_rsp("midrst tie", 1'b0, 16'h0000, 1'b1);
        step();
        chk("final busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
